// File: rtl/uart_cmd_responder_if.sv
// rtl/uart_cmd_responder_if.sv - byte stream handshake bundle
// Purpose: one-byte valid/ready stream used for both the received-byte path
// and the response path of uart_cmd_responder.
// Signals: tdata[7:0] byte, tvalid byte present, tready byte taken.
// Modports: master drives tdata/tvalid and samples tready; slave is the mirror.
interface uart_cmd_responder_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_cmd_responder.sv
// rtl/uart_cmd_responder.sv - UART register command frame responder
// Purpose: decodes 'W' addr data / 'R' addr frames from received bytes,
// performs one register access and returns one response byte.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   s_axis (slave)        received bytes from the UART
//   m_axis (master)       response byte toward the UART transmitter
//   rx_frame_error        UART receive framing-error pulse
//   reg_addr/reg_wdata    access address and write data
//   reg_wr/reg_rd         access strobes, held until reg_ack or timeout
//   reg_rdata/reg_ack     read data and access completion
//   busy                  responder is not idle
//   ack_timeout           pulse when an access is abandoned
//   frame_abort           pulse when a partial frame is dropped
module uart_cmd_responder #(
  parameter int ACK_TIMEOUT   = 255,
  parameter int FRAME_TIMEOUT = 65535
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_cmd_responder_if.slave         s_axis,
  uart_cmd_responder_if.master        m_axis,
  input  logic                        rx_frame_error,
  output logic [7:0]                  reg_addr,
  output logic [7:0]                  reg_wdata,
  output logic                        reg_wr,
  output logic                        reg_rd,
  input  logic [7:0]                  reg_rdata,
  input  logic                        reg_ack,
  output logic                        busy,
  output logic                        ack_timeout,
  output logic                        frame_abort
);

  localparam logic [7:0]  OP_WRITE    = 8'h57;
  localparam logic [7:0]  OP_READ     = 8'h52;
  localparam logic [7:0]  RSP_ACK     = 8'h4B;
  localparam logic [7:0]  RSP_UNKNOWN = 8'h3F;
  localparam logic [7:0]  RSP_TIMEOUT = 8'h54;
  localparam logic [15:0] ACK_LIMIT   = 16'(ACK_TIMEOUT);
  localparam logic [15:0] FRAME_LIMIT = 16'(FRAME_TIMEOUT);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, ACCESS, RESP} state_t;

  state_t      state;
  logic        is_write;
  logic [15:0] ack_cnt;
  logic [15:0] frame_cnt;
  logic        byte_in;

  assign byte_in = s_axis.tvalid & s_axis.tready;

  // Every output is a register; s_axis.tready is written alongside each state
  // change so it already reflects the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      is_write      <= 1'b0;
      ack_cnt       <= '0;
      frame_cnt     <= '0;
      s_axis.tready <= 1'b0;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      reg_addr      <= '0;
      reg_wdata     <= '0;
      reg_wr        <= 1'b0;
      reg_rd        <= 1'b0;
      busy          <= 1'b0;
      ack_timeout   <= 1'b0;
      frame_abort   <= 1'b0;
    end else begin
      ack_timeout <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          s_axis.tready <= 1'b1;
          if (byte_in) begin
            busy <= 1'b1;
            if (s_axis.tdata == OP_WRITE || s_axis.tdata == OP_READ) begin
              is_write  <= (s_axis.tdata == OP_WRITE);
              frame_cnt <= '0;
              state     <= ADDR;
            end else begin
              m_axis.tdata  <= RSP_UNKNOWN;
              m_axis.tvalid <= 1'b1;
              s_axis.tready <= 1'b0;
              state         <= RESP;
            end
          end
        end

        ADDR, WDATA: begin
          // A framing error beats a byte arriving in the same cycle; that
          // byte is still handshaked (tready stays high) and then dropped.
          if (rx_frame_error || (!byte_in && frame_cnt + 16'd1 == FRAME_LIMIT)) begin
            frame_abort <= 1'b1;
            frame_cnt   <= '0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (byte_in) begin
            frame_cnt <= '0;
            if (state == ADDR) begin
              reg_addr <= s_axis.tdata;
            end else begin
              reg_wdata <= s_axis.tdata;
            end
            if (state == ADDR && is_write) begin
              state <= WDATA;
            end else begin
              s_axis.tready <= 1'b0;
              ack_cnt       <= '0;
              reg_wr        <= is_write;
              reg_rd        <= !is_write;
              state         <= ACCESS;
            end
          end else begin
            frame_cnt <= frame_cnt + 16'd1;
          end
        end

        ACCESS: begin
          // Ack is checked first so an ack on the limit cycle still completes.
          if (reg_ack) begin
            reg_wr        <= 1'b0;
            reg_rd        <= 1'b0;
            m_axis.tdata  <= is_write ? RSP_ACK : reg_rdata;
            m_axis.tvalid <= 1'b1;
            state         <= RESP;
          end else if (ack_cnt + 16'd1 == ACK_LIMIT) begin
            reg_wr        <= 1'b0;
            reg_rd        <= 1'b0;
            m_axis.tdata  <= RSP_TIMEOUT;
            m_axis.tvalid <= 1'b1;
            ack_timeout   <= 1'b1;
            state         <= RESP;
          end else begin
            ack_cnt <= ack_cnt + 16'd1;
          end
        end

        RESP: begin
          if (m_axis.tready) begin
            m_axis.tvalid <= 1'b0;
            s_axis.tready <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end

        default: begin
          state         <= IDLE;
          s_axis.tready <= 1'b0;
          m_axis.tvalid <= 1'b0;
          reg_wr        <= 1'b0;
          reg_rd        <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb/tb_uart_cmd_responder.sv - self-checking bench for uart_cmd_responder
// Purpose: directed and randomized command frames against a frame-level
// reference model; the bench also plays the register bank.
// Ports: none (top-level bench).
module tb_uart_cmd_responder;
  localparam int ACK_T   = 4;
  localparam int FRAME_T = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_frame_error;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_wr, reg_rd, reg_ack, busy, ack_timeout, frame_abort;

  always #5 clk = ~clk;

  uart_cmd_responder_if s_axis();
  uart_cmd_responder_if m_axis();

  uart_cmd_responder #(.ACK_TIMEOUT(ACK_T), .FRAME_TIMEOUT(FRAME_T)) dut (
    .clk(clk), .rst(rst), .s_axis(s_axis), .m_axis(m_axis),
    .rx_frame_error(rx_frame_error), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
    .busy(busy), .ack_timeout(ack_timeout), .frame_abort(frame_abort)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] bank [256];
  logic [7:0] model_mem [256];

  int         ob_width;
  logic [7:0] ob_addr, ob_wdata, ob_resp;
  logic       ob_wr, ob_vld, ob_to, ob_stable, ob_after_vld, ob_after_rdy, ob_after_busy;
  bit         ob_ok;

  // Frame-level expectation: what the host should see for one frame.
  function automatic void model(input logic [7:0] op, input logic [7:0] a, input logic [7:0] wd,
                                input int d, output logic [7:0] resp, output int width,
                                output logic to);
    to = 1'b0;
    if (op != 8'h57 && op != 8'h52) begin
      resp = 8'h3F; width = 0;
    end else if (d < ACK_T) begin
      width = d + 1;
      if (op == 8'h57) begin resp = 8'h4B; model_mem[a] = wd; end
      else resp = model_mem[a];
    end else begin
      width = ACK_T; resp = 8'h54; to = 1'b1;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int n = 0;
    @(negedge clk);
    s_axis.tdata = b; s_axis.tvalid = 1'b1;
    while (s_axis.tready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    ok = (s_axis.tready === 1'b1);
    @(posedge clk); #1;
    s_axis.tvalid = 1'b0;
  endtask

  // Drives one frame, plays the register bank with ack delay d, holds the
  // response for bp cycles, then accepts it. Results land in ob_*.
  task automatic run_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] wd,
                           input int d, input int bp);
    bit ok;
    ob_ok = 1'b1; ob_width = 0; ob_addr = 0; ob_wdata = 0; ob_wr = 0;
    send_byte(op, ok); ob_ok &= ok;
    if (op == 8'h57 || op == 8'h52) begin
      send_byte(a, ok); ob_ok &= ok;
      if (op == 8'h57) begin send_byte(wd, ok); ob_ok &= ok; end
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        reg_ack = 1'b0;
        if (reg_wr || reg_rd) begin
          ob_width++;
          if (ob_width == 1) begin ob_addr = reg_addr; ob_wdata = reg_wdata; ob_wr = reg_wr; end
          if (ob_width == d + 1) begin
            reg_ack = 1'b1; reg_rdata = bank[reg_addr];
            if (reg_wr) bank[reg_addr] = reg_wdata;
          end
        end else if (ob_width > 0) break;
      end
      reg_ack = 1'b0;
    end else begin
      @(negedge clk);
      ob_width = (reg_wr || reg_rd) ? 1 : 0;
    end
    ob_vld = m_axis.tvalid; ob_resp = m_axis.tdata; ob_to = ack_timeout;
    ob_stable = 1'b1;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== ob_resp || s_axis.tready !== 1'b0) ob_stable = 1'b0;
    end
    m_axis.tready = 1'b1;
    @(posedge clk); #1;
    m_axis.tready = 1'b0;
    @(negedge clk);
    ob_after_vld = m_axis.tvalid; ob_after_rdy = s_axis.tready; ob_after_busy = busy;
  endtask

  task automatic test_reset();
    logic [30:0] outs;
    rst = 1'b0; s_axis.tvalid = 0; s_axis.tdata = 0; m_axis.tready = 0;
    reg_ack = 0; reg_rdata = 0; rx_frame_error = 0;
    for (int i = 0; i < 256; i++) begin bank[i] = 8'($urandom); model_mem[i] = bank[i]; end
    repeat (3) @(negedge clk);
    outs = {s_axis.tready, m_axis.tvalid, m_axis.tdata, reg_wr, reg_rd, reg_addr, reg_wdata,
            busy, ack_timeout, frame_abort};
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL reset_outputs got %h want 0", outs); end
    rst = 1'b1;
    n_cmp++; if (s_axis.tready !== 1'b0) begin n_bad++; $display("FAIL reset_tready_pre got %b want 0", s_axis.tready); end
    @(negedge clk);
    n_cmp++; if (s_axis.tready !== 1'b1) begin n_bad++; $display("FAIL reset_tready_post got %b want 1", s_axis.tready); end
  endtask

  task automatic test_write();
    logic [7:0] er; int ew; logic eto;
    model(8'h57, 8'h10, 8'hA5, 2, er, ew, eto);
    run_frame(8'h57, 8'h10, 8'hA5, 2, 1);
    n_cmp++; if (ob_width !== 3) begin n_bad++; $display("FAIL write_width got %0d want 3", ob_width); end
    n_cmp++; if ({ob_wr, ob_addr, ob_wdata} !== {1'b1, 8'h10, 8'hA5}) begin n_bad++; $display("FAIL write_bus got wr=%b a=%h d=%h want 1 10 a5", ob_wr, ob_addr, ob_wdata); end
    n_cmp++; if ({ob_vld, ob_resp} !== {1'b1, 8'h4B}) begin n_bad++; $display("FAIL write_resp got v=%b %h want 1 4b", ob_vld, ob_resp); end
    n_cmp++; if ({ob_after_vld, ob_after_rdy, ob_after_busy} !== 3'b010) begin n_bad++; $display("FAIL write_after got %b want 010", {ob_after_vld, ob_after_rdy, ob_after_busy}); end
  endtask

  task automatic test_read();
    bank[8'h22] = 8'h3C; model_mem[8'h22] = 8'h3C;
    run_frame(8'h52, 8'h22, 8'h00, 0, 0);
    n_cmp++; if (ob_width !== 1) begin n_bad++; $display("FAIL read_width got %0d want 1", ob_width); end
    n_cmp++; if ({ob_wr, ob_addr} !== {1'b0, 8'h22}) begin n_bad++; $display("FAIL read_bus got wr=%b a=%h want 0 22", ob_wr, ob_addr); end
    n_cmp++; if ({ob_vld, ob_resp} !== {1'b1, 8'h3C}) begin n_bad++; $display("FAIL read_resp got v=%b %h want 1 3c", ob_vld, ob_resp); end
  endtask

  task automatic test_unknown();
    run_frame(8'h41, 8'h00, 8'h00, 0, 2);
    n_cmp++; if ({ob_vld, ob_resp, ob_width} !== {1'b1, 8'h3F, 32'd0}) begin n_bad++; $display("FAIL unknown_resp got v=%b %h w=%0d want 1 3f 0", ob_vld, ob_resp, ob_width); end
    run_frame(8'h52, 8'h22, 8'h00, 1, 0);
    n_cmp++; if ({ob_resp, ob_width} !== {8'h3C, 32'd2}) begin n_bad++; $display("FAIL unknown_next_read got %h w=%0d want 3c 2", ob_resp, ob_width); end
  endtask

  task automatic test_ack_timeout();
    logic [7:0] er; int ew; logic eto;
    model(8'h57, 8'h05, 8'h77, 100, er, ew, eto);
    run_frame(8'h57, 8'h05, 8'h77, 100, 0);
    n_cmp++; if (ob_width !== ACK_T) begin n_bad++; $display("FAIL timeout_width got %0d want %0d", ob_width, ACK_T); end
    n_cmp++; if ({ob_to, ob_vld, ob_resp} !== {2'b11, 8'h54}) begin n_bad++; $display("FAIL timeout_resp got to=%b v=%b %h want 1 1 54", ob_to, ob_vld, ob_resp); end
  endtask

  task automatic test_frame_timeout();
    bit ok; int abort_at = 0; logic saw_vld = 0;
    send_byte(8'h57, ok);
    for (int i = 1; i <= 20 && abort_at == 0; i++) begin
      @(negedge clk);
      if (frame_abort) abort_at = i;
      if (m_axis.tvalid) saw_vld = 1'b1;
    end
    n_cmp++; if (abort_at !== FRAME_T + 1) begin n_bad++; $display("FAIL frame_timeout_at got %0d want %0d", abort_at, FRAME_T + 1); end
    @(negedge clk);
    n_cmp++; if ({saw_vld, m_axis.tvalid, frame_abort, busy, s_axis.tready} !== 5'b00001) begin n_bad++; $display("FAIL frame_timeout_after got %b want 00001", {saw_vld, m_axis.tvalid, frame_abort, busy, s_axis.tready}); end
  endtask

  task automatic test_frame_error();
    bit ok; logic quiet = 1'b1;
    send_byte(8'h57, ok); send_byte(8'h33, ok);
    @(negedge clk);
    s_axis.tdata = 8'h99; s_axis.tvalid = 1'b1; rx_frame_error = 1'b1;
    @(posedge clk); #1;
    s_axis.tvalid = 1'b0; rx_frame_error = 1'b0;
    @(negedge clk);
    n_cmp++; if ({frame_abort, busy, s_axis.tready, m_axis.tvalid} !== 4'b1010) begin n_bad++; $display("FAIL frame_error got %b want 1010", {frame_abort, busy, s_axis.tready, m_axis.tvalid}); end
    repeat (6) begin
      @(negedge clk);
      if (m_axis.tvalid || reg_wr || reg_rd || frame_abort) quiet = 1'b0;
    end
    n_cmp++; if (quiet !== 1'b1) begin n_bad++; $display("FAIL frame_error_quiet got %b want 1", quiet); end
  endtask

  task automatic test_backpressure();
    logic [7:0] er; int ew; logic eto;
    model(8'h52, 8'h10, 8'h00, 1, er, ew, eto);
    run_frame(8'h52, 8'h10, 8'h00, 1, 20);
    n_cmp++; if ({ob_stable, ob_resp} !== {1'b1, er}) begin n_bad++; $display("FAIL backpressure got stable=%b %h want 1 %h", ob_stable, ob_resp, er); end
  endtask

  task automatic test_reset_mid();
    bit ok; logic [30:0] outs;
    send_byte(8'h57, ok); send_byte(8'h44, ok); send_byte(8'h55, ok);
    for (int i = 0; i < 10 && reg_wr !== 1'b1; i++) @(negedge clk);
    n_cmp++; if (reg_wr !== 1'b1) begin n_bad++; $display("FAIL reset_mid_strobe got %b want 1", reg_wr); end
    #2 rst = 1'b0;
    #1;
    outs = {s_axis.tready, m_axis.tvalid, m_axis.tdata, reg_wr, reg_rd, reg_addr, reg_wdata,
            busy, ack_timeout, frame_abort};
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL reset_mid_outputs got %h want 0", outs); end
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({s_axis.tready, m_axis.tvalid, busy} !== 3'b100) begin n_bad++; $display("FAIL reset_mid_recover got %b want 100", {s_axis.tready, m_axis.tvalid, busy}); end
  endtask

  task automatic test_random();
    logic [7:0] op, a, wd, er; int d, bp, sel, ew; logic eto;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 4);
      op  = (sel < 2) ? 8'h57 : (sel < 4) ? 8'h52 : 8'($urandom);
      a   = 8'($urandom); wd = 8'($urandom);
      d   = $urandom_range(0, 5); bp = $urandom_range(0, 3);
      model(op, a, wd, d, er, ew, eto);
      run_frame(op, a, wd, d, bp);
      n_cmp++;
      if (!ob_ok || ob_vld !== 1'b1 || ob_resp !== er || ob_width !== ew || ob_to !== eto || ob_stable !== 1'b1 ||
          {ob_after_vld, ob_after_rdy, ob_after_busy} !== 3'b010 ||
          (ew > 0 && (ob_addr !== a || ob_wr !== (op == 8'h57) || (op == 8'h57 && ob_wdata !== wd)))) begin
        n_bad++;
        $display("FAIL random_frame%0d op=%h a=%h d=%0d got resp=%h w=%0d to=%b addr=%h wd=%h want resp=%h w=%0d to=%b addr=%h wd=%h",
                 n, op, a, d, ob_resp, ob_width, ob_to, ob_addr, ob_wdata, er, ew, eto, a, wd);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_unknown();
    test_ack_timeout();
    test_frame_timeout();
    test_frame_error();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Byte-level command responder on the far side of the AXI4-Stream UART: it consumes received bytes, decodes a 2–3 byte read/write command frame, performs one access on a simple register port, and returns a single response byte toward the UART transmitter. Sits between the UART's received-byte stream and the local register bank; it is the device-side answer to a host issuing register commands over the serial link.

## Interface
- ACK_TIMEOUT, 255: cycles to wait for reg_ack before aborting the access; 1..65535.
- FRAME_TIMEOUT, 65535: idle cycles allowed between bytes of one frame; 1..65535.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  8  received byte from the UART.
- s_axis_tvalid  in  1  received byte valid.
- s_axis_tready  out  1  responder accepts a byte.
- m_axis_tdata  out  8  response byte to the UART transmitter.
- m_axis_tvalid  out  1  response valid.
- m_axis_tready  in  1  transmitter accepts the response.
- rx_frame_error  in  1  UART receive framing-error pulse.
- reg_addr  out  8  access address.
- reg_wdata  out  8  write data.
- reg_wr  out  1  write request, a level held until acked.
- reg_rd  out  1  read request, a level held until acked.
- reg_rdata  in  8  read data, valid with reg_ack.
- reg_ack  in  1  access complete.
- busy  out  1  state is not IDLE.
- ack_timeout  out  1  one-cycle pulse when an access times out.
- frame_abort  out  1  one-cycle pulse when a partial frame is discarded.

## Operation
- Frames:
  - Write: 0x57 ('W'), addr, data.
  - Read: 0x52 ('R'), addr.
- Responses:
  - Write ack: 0x4B ('K').
  - Read: the read data byte.
  - Unknown opcode: 0x3F ('?').
  - Access timeout: 0x54 ('T').
- States and transitions:
  - IDLE: tready=1. A 'W' or 'R' latches the op and goes to ADDR. Any other byte latches resp=0x3F and goes to RESP.
  - ADDR: tready=1. A byte latches reg_addr. Next state is WDATA for a write, ACCESS for a read.
  - WDATA: tready=1. A byte latches reg_wdata, then ACCESS.
  - ACCESS: tready=0. reg_wr or reg_rd is high for the whole state. On reg_ack: drop the strobe, latch resp (reg_rdata for a read, 0x4B for a write), then RESP.
  - RESP: tready=0, tvalid=1, tdata=resp held stable. On tready, go to IDLE.
- Ack timeout: a 16-bit counter clears on entry to ACCESS and increments each cycle without ack. When it reaches ACK_TIMEOUT: resp=0x54, pulse ack_timeout, go to RESP.
- Frame timeout: a 16-bit counter clears on every accepted byte and increments in ADDR/WDATA. When it reaches FRAME_TIMEOUT: go to IDLE, no response, pulse frame_abort.
- rx_frame_error:
  - In ADDR/WDATA: go to IDLE, no response, pulse frame_abort.
  - In IDLE/ACCESS/RESP: ignored.
- Error and byte in the same cycle in ADDR/WDATA: the error wins; the byte is handshaked and discarded.
- reg_ack outside ACCESS is ignored. reg_ack on the same cycle the timeout count is reached: ack wins.
- Exactly one response per completed or unknown-opcode frame; none for aborted frames.

## Timing
- All outputs are registered.
- Reset values:
  - s_axis_tready=0; it rises on the first rising edge after rst deasserts.
  - m_axis_tvalid=0, m_axis_tdata=0.
  - reg_wr=0, reg_rd=0, reg_addr=0, reg_wdata=0.
  - busy=0, ack_timeout=0, frame_abort=0.
  - state=IDLE.
- Last frame byte accepted at edge N: tready=0 and the strobe is high from N+1.
- reg_ack sampled high at edge M: the strobe is low and tvalid=1 from M+1.
- Zero-wait ack (ack in the first strobe cycle): strobe width 1 cycle.
- Response accepted at edge K: tready=1 from K+1. There is no overlap between response and next frame.
- tvalid, once high, is never withdrawn before tready, except by reset.
- Reset mid-operation: strobes drop immediately (asynchronous), any pending response is discarded, and counters clear.

## Test plan
- Write: send 0x57, 0x10, 0xA5; ack after 3 cycles -> reg_wr high 3 cycles with addr=0x10, wdata=0xA5; response 0x4B; busy low afterwards.
- Read: send 0x52, 0x22; reg_rdata=0x3C with zero-wait ack -> reg_rd width 1; response 0x3C at ack+1.
- Unknown opcode: send 0x41 -> response 0x3F; no strobe; the next 'R' frame works normally.
- Ack timeout: ACK_TIMEOUT=4, never ack -> strobe high 4 cycles; ack_timeout pulse; response 0x54.
- Aborts:
  - FRAME_TIMEOUT=8, send 0x57 only -> frame_abort after 8 idle cycles; no response.
  - rx_frame_error in WDATA -> frame_abort; no response.
- Backpressure/reset: hold m_axis_tready low 20 cycles -> tvalid and tdata stable, s_axis_tready=0. Assert rst during ACCESS -> all outputs at reset values immediately.
